// File: rtl/controle_busca_pkg.sv
// ============================================================================
// Module      : controle_busca_pkg
// Description : Shared types and constants for the instruction-fetch sequencer
//               (state encoding, address and instruction widths).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package controle_busca_pkg;

    localparam int PC_W          = 64;
    localparam int INST_W        = 32;
    localparam int DEF_MEM_WORDS = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HALT  = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/controle_busca_if.sv
// ============================================================================
// Module      : controle_busca_if
// Description : Bundles the instruction-memory address/data pair, the
//               valid/ready decode handshake and the branch redirect request.
//               The master side is the fetch sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface controle_busca_if;
    import controle_busca_pkg::*;

    logic [PC_W-1:0]   pc_mem;
    logic [INST_W-1:0] instr_mem;
    logic [INST_W-1:0] inst_out;
    logic [PC_W-1:0]   inst_pc;
    logic              inst_valid;
    logic              inst_ready;
    logic              flush;
    logic [PC_W-1:0]   flush_pc;

    modport master (
        output pc_mem, inst_out, inst_pc, inst_valid,
        input  instr_mem, inst_ready, flush, flush_pc
    );

    modport slave (
        input  pc_mem, inst_out, inst_pc, inst_valid,
        output instr_mem, inst_ready, flush, flush_pc
    );
endinterface

`default_nettype wire

// File: rtl/controle_busca_saida_reg.sv
// ============================================================================
// Module      : busca_saida_reg
// Description : Single-entry valid/ready output stage towards decode. Holds
//               an instruction and its word address; clear drops the valid
//               flag and takes priority over load.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module busca_saida_reg
    import controle_busca_pkg::*;
(
    input  wire logic              clk,
    input  wire logic              rst_n,
    input  wire logic              i_load,
    input  wire logic              i_clear,
    input  wire logic [INST_W-1:0] i_inst,
    input  wire logic [PC_W-1:0]   i_pc,
    output logic      [INST_W-1:0] o_inst,
    output logic      [PC_W-1:0]   o_pc,
    output logic                   o_valid
);

    logic [INST_W-1:0] inst_q, inst_d;
    logic [PC_W-1:0]   pc_q,   pc_d;
    logic              valid_q, valid_d;

    // Next-state: hold by default, clear wins over load.
    always_comb begin
        inst_d  = inst_q;
        pc_d    = pc_q;
        valid_d = valid_q;
        if (i_clear) begin
            valid_d = 1'b0;
        end else if (i_load) begin
            inst_d  = i_inst;
            pc_d    = i_pc;
            valid_d = 1'b1;
        end
    end

    // Stage registers with synchronous active-low reset to an empty slot.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            inst_q  <= '0;
            pc_q    <= '0;
            valid_q <= 1'b0;
        end else begin
            inst_q  <= inst_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
        end
    end

    assign o_inst  = inst_q;
    assign o_pc    = pc_q;
    assign o_valid = valid_q;

endmodule

`default_nettype wire

// File: rtl/controle_busca.sv
// ============================================================================
// Module      : controle_busca
// Description : Instruction-fetch sequencer. Owns the program counter, drives
//               the word address of the combinational instruction ROM and
//               registers each returned word into a one-entry valid/ready
//               stage. Handles start (run), branch redirect (flush) and halt
//               when the PC runs past the end of memory.
//               Optional build macro FETCH_PERF_EN adds fetch_count and
//               flush_count performance counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module controle_busca
    import controle_busca_pkg::*;
#(
    parameter int              MEM_WORDS = DEF_MEM_WORDS,
    parameter logic [PC_W-1:0] RESET_PC  = '0
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    input  wire logic         run,
    output logic              halted,
`ifdef FETCH_PERF_EN
    output logic [31:0]       fetch_count,
    output logic [31:0]       flush_count,
`endif
    controle_busca_if.master  bus
);

    localparam logic [PC_W-1:0] C_MEM_LIMIT = PC_W'(MEM_WORDS);

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q,    pc_d;
    logic            out_load;
    logic            out_clear;
    logic            flush_taken;
    logic            adv;
    logic            xfer;

    // A new fetch may issue only when enabled and the output slot is free
    // or being drained this cycle.
    assign adv  = run && (!bus.inst_valid || bus.inst_ready);
    assign xfer = bus.inst_valid && bus.inst_ready;

    // Next-state, PC update and output-stage control.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        out_load    = 1'b0;
        out_clear   = 1'b0;
        flush_taken = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.flush) begin
                    pc_d = bus.flush_pc;
                end else if (run) begin
                    state_d = FETCH;
                end
            end
            FETCH: begin
                if (bus.flush) begin
                    // Redirect discards the held word; a same-cycle transfer
                    // has already been taken by decode.
                    flush_taken = 1'b1;
                    pc_d        = bus.flush_pc;
                    out_clear   = 1'b1;
                    if (bus.flush_pc >= C_MEM_LIMIT) begin
                        state_d = HALT;
                    end
                end else if (adv && (pc_q < C_MEM_LIMIT)) begin
                    out_load = 1'b1;
                    pc_d     = pc_q + 64'd1;
                end else if (adv) begin
                    out_clear = 1'b1;
                    state_d   = HALT;
                end
            end
            HALT: begin
                out_clear = 1'b1;
                if (bus.flush) begin
                    flush_taken = 1'b1;
                    pc_d        = bus.flush_pc;
                    if (bus.flush_pc < C_MEM_LIMIT) begin
                        state_d = FETCH;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and PC registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    busca_saida_reg u_saida (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (out_load),
        .i_clear (out_clear),
        .i_inst  (bus.instr_mem),
        .i_pc    (pc_q),
        .o_inst  (bus.inst_out),
        .o_pc    (bus.inst_pc),
        .o_valid (bus.inst_valid)
    );

    assign bus.pc_mem = pc_q;
    assign halted     = (state_q == HALT);

`ifdef FETCH_PERF_EN
    logic [31:0] fetch_count_q, fetch_count_d;
    logic [31:0] flush_count_q, flush_count_d;

    // Counter increments; both wrap naturally at 2^32.
    always_comb begin
        fetch_count_d = fetch_count_q;
        flush_count_d = flush_count_q;
        if (xfer) begin
            fetch_count_d = fetch_count_q + 32'd1;
        end
        if (flush_taken) begin
            flush_count_d = flush_count_q + 32'd1;
        end
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_count_q <= '0;
            flush_count_q <= '0;
        end else begin
            fetch_count_q <= fetch_count_d;
            flush_count_q <= flush_count_d;
        end
    end

    assign fetch_count = fetch_count_q;
    assign flush_count = flush_count_q;
`else
    // Transfer and flush qualifiers only feed the optional counters.
    logic unused_perf;
    assign unused_perf = xfer ^ flush_taken;
`endif

endmodule

`default_nettype wire

// File: doc/controle_busca.md
Name: controle_busca

Overview:
Instruction-fetch sequencer that owns the program counter and drives the word address of memoria_instrucao. memoria_instrucao is a combinational ROM with 64 words, indexed by word, that returns 0 when the address is out of range. This block registers each returned instruction into a one-entry valid/ready stage feeding decode. It also handles branch redirects (flush), start control and halt on running off the end of memory.

Parameters:
MEM_WORDS, 64, number of instruction words; any pc >= MEM_WORDS is out of range.
RESET_PC, 0, word address loaded into the PC at reset.

Ports:
clk  in  1  system clock; all state updates on the rising edge.
rst_n  in  1  synchronous, active-low reset, sampled on the rising edge of clk.
run  in  1  start/enable; when 0, no new fetch is issued.
pc_mem  out  64  word address to memoria_instrucao; equals the internal PC register.
instr_mem  in  32  instruction returned combinationally for pc_mem.
inst_out  out  32  registered instruction to decode.
inst_pc  out  64  word address that inst_out was fetched from.
inst_valid  out  1  inst_out/inst_pc hold an unconsumed instruction.
inst_ready  in  1  decode accepts; a transfer occurs when inst_valid && inst_ready.
flush  in  1  redirect request (taken branch).
flush_pc  in  64  word-address redirect target.
halted  out  1  high while in state HALT.

Behaviour:
- Reset (rst_n=0 at an edge):
  - pc=RESET_PC, state=IDLE.
  - inst_out=0, inst_pc=0, inst_valid=0, halted=0.
  - Reset overrides every other input and aborts any pending instruction.
- States are IDLE, FETCH and HALT.
- IDLE:
  - No fetch; inst_valid stays 0.
  - If run=1 → FETCH next cycle.
  - flush in IDLE loads pc=flush_pc and the state stays IDLE.
- FETCH: define adv = run && (!inst_valid || inst_ready). Evaluate in this priority order:
  1. flush=1: pc<=flush_pc, inst_valid<=0, discarding any held instruction. A same-cycle transfer still counts as accepted by decode. If flush_pc >= MEM_WORDS, go to HALT.
  2. adv && pc<MEM_WORDS: inst_out<=instr_mem, inst_pc<=pc, inst_valid<=1, pc<=pc+1.
  3. adv && pc>=MEM_WORDS: inst_valid<=0, go to HALT.
  4. Otherwise (stall, or run=0): hold pc, inst_out, inst_pc and inst_valid unchanged.
- HALT:
  - halted=1, inst_valid=0, pc frozen.
  - flush with flush_pc<MEM_WORDS: pc<=flush_pc, go to FETCH, halted<=0.
  - flush with an out-of-range target: stay in HALT, pc<=flush_pc.
  - Exit only via such a flush or via reset.
- Latency and throughput:
  - The instruction at word p appears on inst_out with inst_valid one cycle after pc_mem=p.
  - Sustained throughput is 1 instruction/cycle while inst_ready=1 and no flush.
  - The cycle after a flush delivers nothing (1-cycle bubble).
- Arithmetic: pc+1 is a 64-bit add with natural wrap. Wrap is unreachable in practice because pc>=MEM_WORDS halts first.
- A zero instruction word is treated as ordinary data and does not halt.
- Deasserting run mid-stream does not drop the held instruction; it remains valid until accepted.

Optional Feature:
FETCH_PERF_EN
- Defined: adds outputs fetch_count[31:0] and flush_count[31:0], both reset to 0 and wrapping at 2^32.
  - fetch_count increments on every transfer (inst_valid && inst_ready).
  - flush_count increments on every flush accepted in FETCH or HALT.
- Undefined: neither port nor counter exists; all other behaviour is identical.

Decomposition:
- Package controle_busca_pkg holds:
  - the state enum (IDLE, FETCH, HALT);
  - constants PC_W=64, INST_W=32, default MEM_WORDS=64.
- One natural sub-module, busca_saida_reg: the single-entry valid/ready output register with load, hold and clear controls, instantiated once.

Test Plan:
1. Reset, then run=1, inst_ready=1, bench ROM loaded with the team test program → inst_out sequence is 0x00000000 (pc0), 0x00102103 (pc1), 0x00208233 (pc2), one per cycle; first valid appears 2 cycles after run rises.
2. Backpressure: inst_ready=0 for 3 cycles while inst_valid=1 at pc=2 → inst_out=0x00208233, inst_pc=2 and pc_mem=3 are held; ready=1 → pc3 delivered next cycle with no loss or duplication.
3. Flush with flush_pc=5 in the same cycle as a transfer at pc=6 → next cycle inst_valid=0 and pc_mem=5; the following cycle inst_pc=5.
4. Run off the end (no flush) → after inst_pc=63 is accepted, halted=1 and inst_valid=0. Then flush_pc=1 → halted=0 and inst_pc=1 delivered 2 cycles later.
5. flush_pc=64 while in FETCH → halted=1 next cycle and nothing delivered; rst_n=0 while inst_valid=1 → all outputs 0 and pc_mem=RESET_PC on the next edge.
6. With FETCH_PERF_EN defined: 10 transfers and 2 flushes → fetch_count=10, flush_count=2; both return to 0 on reset.
